// File: rtl/wb_store_queue.sv
`default_nettype none
//==============================================================================
// Module   : wb_store_queue
// Purpose  : In-order write-back store queue draining committed stores to the
//            data cache over req/ack; optional load-overlap probe enabled by
//            the WBAQ_LD_PROBE_EN macro.
// Revision : 1.0 - initial release
//==============================================================================
module wb_store_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [1:0]    wr_size,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          dc_req,
    output logic [AW-1:0] dc_addr,
    output logic [DW-1:0] dc_data,
    output logic [1:0]    dc_size,
    input  logic          dc_ack,
    input  logic          ld_probe_valid,
    input  logic [AW-1:0] ld_probe_addr,
    input  logic [1:0]    ld_probe_size,
    output logic          ld_probe_hit
);

    localparam int          PW        = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [1:0]    size_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic w_full, w_empty, w_push, w_pop;

    assign w_full  = (count_q == C_DEPTH);
    assign w_empty = (count_q == '0);
    assign w_push  = wr_valid & ~w_full;
    assign w_pop   = ~w_empty & dc_ack;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q | (wr_valid & w_full);
        if (w_push) begin
            tail_d = tail_q + PW'(1);
        end
        if (w_pop) begin
            head_d = head_q + PW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    addr_q[i] <= '0;
                    data_q[i] <= '0;
                    size_q[i] <= '0;
                end else if (w_push && (tail_q == PW'(i))) begin
                    addr_q[i] <= wr_addr;
                    data_q[i] <= wr_data;
                    size_q[i] <= wr_size;
                end
            end
        end
    endgenerate

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign dc_req   = ~w_empty;
    assign dc_addr  = addr_q[head_q];
    assign dc_data  = data_q[head_q];
    assign dc_size  = size_q[head_q];

`ifdef WBAQ_LD_PROBE_EN
    // Inclusive end of a byte span, one bit wider than the address so it never wraps.
    function automatic logic [AW:0] span_end(input logic [AW-1:0] a, input logic [1:0] s);
        return {1'b0, a} + (((AW+1)'(1)) << s) - (AW+1)'(1);
    endfunction

    logic [DEPTH-1:0] w_match;
    logic [AW:0]      w_p_start, w_p_end;

    assign w_p_start = {1'b0, ld_probe_addr};
    assign w_p_end   = span_end(ld_probe_addr, ld_probe_size);

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_probe
            logic [PW-1:0] w_off;
            logic          w_valid;
            logic [AW:0]   w_e_start, w_e_end;
            // Slot is live when its distance from head is below the registered count.
            assign w_off      = PW'(i) - head_q;
            assign w_valid    = (CW'(w_off) < count_q);
            assign w_e_start  = {1'b0, addr_q[i]};
            assign w_e_end    = span_end(addr_q[i], size_q[i]);
            assign w_match[i] = w_valid & (w_e_start <= w_p_end) & (w_p_start <= w_e_end);
        end
    endgenerate

    assign ld_probe_hit = ld_probe_valid & (|w_match);
`else
    logic w_probe_unused;
    assign w_probe_unused = ^{ld_probe_valid, ld_probe_addr, ld_probe_size};
    assign ld_probe_hit   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_store_queue.sv
`default_nettype none
//==============================================================================
// Module   : tb_wb_store_queue
// Purpose  : Directed self-checking bench for wb_store_queue.
// Revision : 1.0 - initial release
//==============================================================================
module tb_wb_store_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_size;
    logic        full, empty, overflow, dc_req, dc_ack;
    logic [3:0]  count;
    logic [31:0] dc_addr;
    logic [63:0] dc_data;
    logic [1:0]  dc_size;
    logic        ld_probe_valid;
    logic [31:0] ld_probe_addr;
    logic [1:0]  ld_probe_size;
    logic        ld_probe_hit;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_store_queue #(.DEPTH(8), .AW(32), .DW(64), .CW(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_size        (wr_size),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .dc_req         (dc_req),
        .dc_addr        (dc_addr),
        .dc_data        (dc_data),
        .dc_size        (dc_size),
        .dc_ack         (dc_ack),
        .ld_probe_valid (ld_probe_valid),
        .ld_probe_addr  (ld_probe_addr),
        .ld_probe_size  (ld_probe_size),
        .ld_probe_hit   (ld_probe_hit)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_size = s;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({full, empty, count, overflow, dc_req} !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_flags got f=%b e=%b c=%0d o=%b r=%b want 0 1 0 0 0",
                     full, empty, count, overflow, dc_req);
        end
        n_vec++;
        if ({dc_addr, dc_data, dc_size, ld_probe_hit} !== {32'd0, 64'd0, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_data got a=%h d=%h s=%0d hit=%b want zeros",
                     dc_addr, dc_data, dc_size, ld_probe_hit);
        end
    endtask

    task automatic test_fifo_order();
        logic [31:0] exp_a [3];
        logic [1:0]  exp_s [3];
        exp_a[0] = 32'h100; exp_a[1] = 32'h108; exp_a[2] = 32'h10C;
        exp_s[0] = 2'd3;    exp_s[1] = 2'd2;    exp_s[2] = 2'd0;
        push(32'h100, 64'hA0, 2'd3);
        n_vec++;
        if (dc_req !== 1'b1 || dc_addr !== 32'h100) begin
            n_err++;
            $display("FAIL enq_latency got req=%b addr=%h want 1 100", dc_req, dc_addr);
        end
        push(32'h108, 64'hA1, 2'd2);
        push(32'h10C, 64'hA2, 2'd0);
        tick();
        n_vec++;
        if (count !== 4'd3 || dc_addr !== 32'h100 || dc_data !== 64'hA0 || dc_size !== 2'd3) begin
            n_err++;
            $display("FAIL hold_head got c=%0d a=%h d=%h s=%0d want 3 100 a0 3",
                     count, dc_addr, dc_data, dc_size);
        end
        dc_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (dc_addr !== exp_a[i] || dc_size !== exp_s[i] || dc_data !== 64'(32'hA0 + i)) begin
                n_err++;
                $display("FAIL drain_order[%0d] got a=%h s=%0d d=%h want %h %0d %h",
                         i, dc_addr, dc_size, dc_data, exp_a[i], exp_s[i], 32'hA0 + i);
            end
            tick();
        end
        dc_ack = 1'b0;
        n_vec++;
        if (empty !== 1'b1 || dc_req !== 1'b0) begin
            n_err++;
            $display("FAIL drained_empty got e=%b r=%b want 1 0", empty, dc_req);
        end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 8; i++) push(32'h1000 + 32'(i * 8), 64'(i), 2'd3);
        n_vec++;
        if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fill got c=%0d f=%b o=%b want 8 1 0", count, full, overflow);
        end
        dc_ack = 1'b1;
        push(32'hDEAD, 64'hDEAD, 2'd0);
        dc_ack = 1'b0;
        n_vec++;
        if (count !== 4'd7 || full !== 1'b0 || overflow !== 1'b1 || dc_addr !== 32'h1008) begin
            n_err++;
            $display("FAIL full_push_pop got c=%0d f=%b o=%b a=%h want 7 0 1 1008",
                     count, full, overflow, dc_addr);
        end
        dc_ack = 1'b1;
        for (int i = 1; i < 8; i++) begin
            n_vec++;
            if (dc_addr !== 32'h1000 + 32'(i * 8)) begin
                n_err++;
                $display("FAIL drop_check[%0d] got %h want %h", i, dc_addr, 32'h1000 + 32'(i * 8));
            end
            tick();
        end
        dc_ack = 1'b0;
        n_vec++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_sticky got e=%b o=%b want 1 1", empty, overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        for (int i = 0; i < 4; i++) begin
            push(32'h2000 + 32'(i * 4), 64'(i), 2'd2);
            q.push_back(32'h2000 + 32'(i * 4));
        end
        dc_ack = 1'b1;
        for (int i = 4; i < 24; i++) begin
            n_vec++;
            if (dc_addr !== q[0] || count !== 4'd4) begin
                n_err++;
                $display("FAIL b2b[%0d] got a=%h c=%0d want %h 4", i, dc_addr, count, q[0]);
            end
            void'(q.pop_front());
            q.push_back(32'h2000 + 32'(i * 4));
            push(32'h2000 + 32'(i * 4), 64'(i), 2'd2);
        end
        while (q.size() > 0) begin
            n_vec++;
            if (dc_addr !== q[0] || dc_data !== 64'((q[0] - 32'h2000) >> 2)) begin
                n_err++;
                $display("FAIL b2b_tail got a=%h d=%h want %h", dc_addr, dc_data, q[0]);
            end
            void'(q.pop_front());
            tick();
        end
        dc_ack = 1'b0;
        n_vec++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_empty got %b want 1", empty);
        end
    endtask

    task automatic test_probe();
        logic [31:0] pa [3];
        logic [1:0]  ps [3];
        logic        ph [3];
        pa[0] = 32'h203; ps[0] = 2'd0;
        pa[1] = 32'h204; ps[1] = 2'd3;
        pa[2] = 32'h1FC; ps[2] = 2'd3;
`ifdef WBAQ_LD_PROBE_EN
        ph[0] = 1'b1; ph[1] = 1'b0; ph[2] = 1'b1;
`else
        ph[0] = 1'b0; ph[1] = 1'b0; ph[2] = 1'b0;
`endif
        push(32'h200, 64'h55, 2'd2);
        ld_probe_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_probe_addr = pa[i];
            ld_probe_size = ps[i];
            #1;
            n_vec++;
            if (ld_probe_hit !== ph[i]) begin
                n_err++;
                $display("FAIL probe[%0d] addr=%h size=%0d got %b want %b",
                         i, pa[i], ps[i], ld_probe_hit, ph[i]);
            end
        end
        ld_probe_valid = 1'b0;
        #1;
        n_vec++;
        if (ld_probe_hit !== 1'b0) begin
            n_err++;
            $display("FAIL probe_invalid got %b want 0", ld_probe_hit);
        end
        dc_ack = 1'b1;
        tick();
        dc_ack = 1'b0;
        ld_probe_valid = 1'b1;
        ld_probe_addr  = 32'h203;
        ld_probe_size  = 2'd0;
        #1;
        n_vec++;
        if (ld_probe_hit !== 1'b0) begin
            n_err++;
            $display("FAIL probe_after_pop got %b want 0", ld_probe_hit);
        end
        ld_probe_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) push(32'h3000 + 32'(i), 64'(i), 2'd0);
        n_vec++;
        if (count !== 4'd5 || dc_req !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset got c=%0d r=%b want 5 1", count, dc_req);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (dc_req !== 1'b0 || count !== 4'd0 || full !== 1'b0 || dc_addr !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset got r=%b c=%0d f=%b a=%h want 0 0 0 0",
                     dc_req, count, full, dc_addr);
        end
        tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if (empty !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset got e=%b o=%b want 1 0", empty, overflow);
        end
    endtask

    initial begin
        rst            = 1'b0;
        wr_valid       = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        wr_size        = '0;
        dc_ack         = 1'b0;
        ld_probe_valid = 1'b0;
        ld_probe_addr  = '0;
        ld_probe_size  = '0;
        #12;
        test_reset();
        rst = 1'b1;
        tick();
        test_fifo_order();
        test_full_overflow();
        test_back_to_back();
        test_probe();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_store_queue.md
# wb_store_queue

Write-back address queue: buffers committed memory writes leaving the writeback stage (mem_ld / mem_addr / mem_data / memsize) and drains them in order to the data cache over a req/ack handshake. Its full flag is the wbaq_full input of writeback, which stalls retirement of memory-writing instructions. An optional load-probe port reports address overlap with pending stores so the memory stage can hold a dependent load.

## Interface
- DEPTH, 8, number of entries; power of two, at least 2
- AW, 32, address width
- DW, 64, data width
- CW, 4, count width; must satisfy 2^CW > DEPTH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_valid  in  1  enqueue request; mem_ld from writeback
- wr_addr  in  AW  store byte address
- wr_data  in  DW  store data, right-justified
- wr_size  in  2  00=1B, 01=2B, 10=4B, 11=8B
- full  out  1  queue full; drives wbaq_full
- empty  out  1  no pending entries
- count  out  CW  number of valid entries
- overflow  out  1  sticky: a wr_valid arrived while full
- dc_req  out  1  head entry is presented to the cache
- dc_addr  out  AW  head address
- dc_data  out  DW  head data
- dc_size  out  2  head size
- dc_ack  in  1  cache accepts the head this cycle
- ld_probe_valid  in  1  load address probe valid
- ld_probe_addr  in  AW  load byte address
- ld_probe_size  in  2  load size, same encoding as wr_size
- ld_probe_hit  out  1  probe overlaps a valid entry

## Operation
- Circular buffer with head and tail pointers of log2(DEPTH) bits that wrap DEPTH-1→0, plus a count register.
- push = wr_valid & !full. Writes {addr, data, size} at tail and advances tail.
- pop = dc_req & dc_ack. Advances head.
- count_next = count + push − pop. full = (count == DEPTH), empty = (count == 0); both decode the registered count.
- wr_valid while full: write dropped, state unchanged, overflow set until reset.
- dc_req = !empty. dc_addr, dc_data and dc_size come from the head slot and hold stable while dc_req=1 and dc_ack=0.
- dc_ack while dc_req=0 is ignored.
- Drain order is strictly FIFO. No write merging.
- Probe: entry span is [a, a+2^size−1], computed with AW+1-bit sums so there is no wrap.
  - ld_probe_hit = ld_probe_valid & OR over valid entries of (e_start ≤ p_end & p_start ≤ e_end).
  - An entry popped in the current cycle still counts; an entry pushed in the current cycle does not.

## Timing
- Reset, asserted asynchronously: head, tail, count and overflow go to 0, and all storage is cleared. Outputs become full=0, empty=1, count=0, overflow=0, dc_req=0, dc_addr=0, dc_data=0, dc_size=0, ld_probe_hit=0.
- Reset mid-operation discards all pending stores. dc_req drops without waiting for a clock.
- Enqueue-to-request latency is 1 cycle: push at edge N gives dc_req=1 after edge N. There is no bypass when empty.
- Push and pop in the same cycle:
  - When 0 < count < DEPTH, count is unchanged and both pointers advance.
  - When full, push is refused even if pop occurs; count becomes DEPTH−1.
  - When empty, no pop is possible; only the push occurs.
- ld_probe_hit is combinational from the probe inputs and registered state. No other outputs have a combinational path from any input.

## Configuration
- WBAQ_LD_PROBE_EN defined: overlap comparators are built and ld_probe_hit behaves as in Operation.
- Not defined: the probe ports remain present, ld_probe_hit is tied 0, and no comparators are built.

## Test plan
- Reset, then 3 pushes (0x100/8B, 0x108/4B, 0x10C/1B) with dc_ack=0 → count=3; dc_req=1 with dc_addr=0x100 held. Then dc_ack=1 for 3 cycles → drains 0x100, 0x108, 0x10C in order; empty=1.
- Fill to 8 entries, then wr_valid=1 with dc_ack=1 in the same cycle → push refused; count=7; overflow=1 and stays 1.
- At count=4, push and ack every cycle for 20 cycles → count stays 4; pointers wrap; data order preserved.
- Pending 0x200/4B (WBAQ_LD_PROBE_EN defined):
  - probe 0x203/1B → hit=1
  - probe 0x204/8B → hit=0
  - probe 0x1FC/8B → hit=1
  - with the macro undefined → hit=0 in all three cases
- Drop rst to 0 mid-cycle with 5 entries pending → dc_req, count and full go to 0 immediately without a clock edge; after release, empty=1.
